// File: rtl/sq_pkg.sv
// Shared definitions for the trigger sequencer: state encodings, register map
// offsets and the control-bit positions.
package sq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } sq_state_e;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_PRE_LO  = 3'd1;
  localparam logic [2:0] REG_PRE_HI  = 3'd2;
  localparam logic [2:0] REG_POST_LO = 3'd3;
  localparam logic [2:0] REG_POST_HI = 3'd4;
  localparam logic [2:0] REG_TRIG_LO = 3'd5;
  localparam logic [2:0] REG_TRIG_HI = 3'd6;
  localparam logic [2:0] REG_ZERO    = 3'd7;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  function automatic logic [7:0] sq_status(input sq_state_e st, input logic active);
    return {4'b0000, st, active};
  endfunction

endpackage

// File: rtl/trigger_sequencer.sv
// Pre/post-trigger capture sequencer: streams sample write addresses into a
// capture buffer and records where the trigger landed; configured over Wishbone.
module trigger_sequencer
  import sq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic        sq_trigger,
  output logic        sq_active,
  output logic        capture_we,
  output logic [15:0] capture_addr,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);

  sq_state_e   r_state;
  sq_state_e   w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [15:0] r_capture_addr;
  logic [15:0] w_addr_next;
  logic [15:0] r_trig_pos;
  logic [15:0] w_trig_next;
  logic [15:0] r_pre_count;
  logic [15:0] w_pre_next;
  logic [15:0] r_post_count;
  logic [15:0] w_post_next;

  logic        w_wr;
  logic [2:0]  w_reg_sel;
  logic        w_ctrl_wr;
  logic        w_abort;
  logic        w_start;
  logic        w_cfg_open;
  logic        w_capture;
  logic [15:0] w_cnt_inc;
  logic        w_unused_adr;

  assign w_wr         = wb_cyc_i && wb_stb_i && wb_we_i;
  assign w_reg_sel    = wb_adr_i[2:0];
  assign w_ctrl_wr    = w_wr && (w_reg_sel == REG_CTRL);
  assign w_abort      = w_ctrl_wr && wb_dat_i[CTRL_ABORT_BIT];
  assign w_start      = w_ctrl_wr && wb_dat_i[CTRL_START_BIT] && !w_abort;
  assign w_cfg_open   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_capture    = sample_valid &&
                        ((r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST));
  assign w_cnt_inc    = r_cnt + 16'd1;
  assign w_unused_adr = ^wb_adr_i[15:3];

  assign capture_we   = w_capture;
  assign capture_addr = r_capture_addr;
  assign sq_active    = (r_state == ST_ARMED);
  assign wb_ack_o     = 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = w_capture ? (r_capture_addr + 16'd1) : r_capture_addr;
    w_trig_next  = r_trig_pos;
    w_pre_next   = r_pre_count;
    w_post_next  = r_post_count;

    if (w_wr && w_cfg_open) begin
      case (w_reg_sel)
        REG_PRE_LO:  w_pre_next[7:0]   = wb_dat_i;
        REG_PRE_HI:  w_pre_next[15:8]  = wb_dat_i;
        REG_POST_LO: w_post_next[7:0]  = wb_dat_i;
        REG_POST_HI: w_post_next[15:8] = wb_dat_i;
        default:     ;
      endcase
    end

    if (w_abort) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = 16'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            w_addr_next  = 16'd0;
            w_trig_next  = 16'd0;
            w_cnt_next   = 16'd0;
            w_state_next = (r_pre_count == 16'd0) ? ST_ARMED : ST_PRE;
          end
        end
        ST_PRE: begin
          if (w_capture) begin
            if (w_cnt_inc == r_pre_count) begin
              w_state_next = ST_ARMED;
              w_cnt_next   = 16'd0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end
        ST_ARMED: begin
          // The sample written on the trigger cycle is the first post-trigger sample.
          if (sq_trigger) begin
            w_trig_next = r_capture_addr;
            if ((r_post_count == 16'd0) || (w_capture && (r_post_count == 16'd1))) begin
              w_state_next = ST_DONE;
              w_cnt_next   = 16'd0;
            end else begin
              w_state_next = ST_POST;
              w_cnt_next   = {15'd0, w_capture};
            end
          end
        end
        ST_POST: begin
          if (w_capture) begin
            if (w_cnt_inc == r_post_count) begin
              w_state_next = ST_DONE;
              w_cnt_next   = 16'd0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 16'd0;
      r_capture_addr <= 16'd0;
      r_trig_pos     <= 16'd0;
      r_pre_count    <= 16'd0;
      r_post_count   <= 16'd0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_capture_addr <= w_addr_next;
      r_trig_pos     <= w_trig_next;
      r_pre_count    <= w_pre_next;
      r_post_count   <= w_post_next;
    end
  end

  always_comb begin
    wb_dat_o = 8'h00;
    case (w_reg_sel)
      REG_CTRL:    wb_dat_o = sq_status(r_state, sq_active);
      REG_PRE_LO:  wb_dat_o = r_pre_count[7:0];
      REG_PRE_HI:  wb_dat_o = r_pre_count[15:8];
      REG_POST_LO: wb_dat_o = r_post_count[7:0];
      REG_POST_HI: wb_dat_o = r_post_count[15:8];
      REG_TRIG_LO: wb_dat_o = r_trig_pos[7:0];
      REG_TRIG_HI: wb_dat_o = r_trig_pos[15:8];
      REG_ZERO:    wb_dat_o = 8'h00;
      default:     wb_dat_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed capture scenarios with literal expectations,
// then randomized traffic compared every cycle against a countdown-style model.
module tb_trigger_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sq_trigger = 1'b0;
  logic        sq_active;
  logic        capture_we;
  logic [15:0] capture_addr;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [15:0] wb_adr_i = 16'd0;
  logic [7:0]  wb_dat_i = 8'd0;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: phase uses the numeric state values 0..4; m_left counts samples still owed.
  int          m_phase;
  int          m_left;
  logic [15:0] m_addr;
  logic [15:0] m_trig;
  logic [15:0] m_pre;
  logic [15:0] m_post;

  trigger_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sq_trigger   (sq_trigger),
    .sq_active    (sq_active),
    .capture_we   (capture_we),
    .capture_addr (capture_addr),
    .wb_stb_i     (wb_stb_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_addr  = 16'd0;
    m_trig  = 16'd0;
    m_pre   = 16'd0;
    m_post  = 16'd0;
  endtask

  function automatic logic m_we();
    return sample_valid && (m_phase >= 1) && (m_phase <= 3);
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] sel);
    logic [2:0] ph;
    ph = 3'(m_phase);
    case (sel)
      3'd0: return {4'b0000, ph, (m_phase == 2)};
      3'd1: return m_pre[7:0];
      3'd2: return m_pre[15:8];
      3'd3: return m_post[7:0];
      3'd4: return m_post[15:8];
      3'd5: return m_trig[7:0];
      3'd6: return m_trig[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    logic       we;
    logic       wr;
    logic [2:0] sel;
    logic [15:0] nxt;
    we  = m_we();
    wr  = wb_cyc_i && wb_stb_i && wb_we_i;
    sel = wb_adr_i[2:0];
    nxt = we ? (m_addr + 16'd1) : m_addr;
    if (wr && sel == 3'd0 && wb_dat_i[1]) begin
      m_phase = 0;
      m_addr  = nxt;
      return;
    end
    if (m_phase == 0 || m_phase == 4) begin
      if (wr && sel == 3'd0 && wb_dat_i[0]) begin
        m_addr = 16'd0;
        m_trig = 16'd0;
        if (m_pre == 16'd0) m_phase = 2;
        else begin
          m_phase = 1;
          m_left  = int'(m_pre);
        end
      end else if (wr) begin
        case (sel)
          3'd1: m_pre[7:0]   = wb_dat_i;
          3'd2: m_pre[15:8]  = wb_dat_i;
          3'd3: m_post[7:0]  = wb_dat_i;
          3'd4: m_post[15:8] = wb_dat_i;
          default: ;
        endcase
      end
      return;
    end
    if (m_phase == 1) begin
      if (we) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (sq_trigger) begin
        m_trig = m_addr;
        m_left = int'(m_post);
        if (we && m_left > 0) m_left--;
        m_phase = (m_left == 0) ? 4 : 3;
      end
    end else begin
      if (we) begin
        m_left--;
        if (m_left == 0) m_phase = 4;
      end
    end
    m_addr = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_sq_active", 32'(sq_active), 32'(m_phase == 2));
        check("cyc_capture_we", 32'(capture_we), 32'(m_we()));
        check("cyc_capture_addr", 32'(capture_addr), 32'(m_addr));
        check("cyc_wb_dat_o", 32'(wb_dat_o), 32'(m_read(wb_adr_i[2:0])));
        check("cyc_wb_ack_o", 32'(wb_ack_o), 32'd1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] sel, input logic [7:0] dat);
    wb_adr_i = {13'd0, sel};
    wb_dat_i = dat;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    tick();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    $display("wb write reg=%0d dat=0x%02h t=%0t", sel, dat, $time);
  endtask

  task automatic rd_check(input string name, input logic [2:0] sel, input logic [7:0] exp);
    wb_adr_i = {13'd0, sel};
    #1;
    check(name, 32'(wb_dat_o), 32'(exp));
  endtask

  initial begin
    model_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rd_check("rst_status", 3'd0, 8'h00);
    check("rst_capture_addr", 32'(capture_addr), 32'd0);
    check("rst_capture_we", 32'(capture_we), 32'd0);
    check("rst_sq_active", 32'(sq_active), 32'd0);
    rst_n = 1'b1;
    tick();

    // pre=4, post=3, continuous samples, trigger two cycles into ARMED
    wb_write(3'd1, 8'd4);
    wb_write(3'd2, 8'd0);
    wb_write(3'd3, 8'd3);
    wb_write(3'd4, 8'd0);
    wb_write(3'd0, 8'h01);
    repeat (4) tick();
    check("s1_armed_active", 32'(sq_active), 32'd1);
    check("s1_armed_addr", 32'(capture_addr), 32'd4);
    repeat (2) tick();
    sq_trigger = 1'b1;
    tick();
    sq_trigger = 1'b0;
    repeat (2) tick();
    rd_check("s1_status_done", 3'd0, 8'h08);
    check("s1_capture_addr", 32'(capture_addr), 32'd9);
    check("s1_model_addr", 32'(m_addr), 32'd9);
    rd_check("s1_trig_lo", 3'd5, 8'd6);
    rd_check("s1_trig_hi", 3'd6, 8'd0);
    check("s1_model_trig", 32'(m_trig), 32'd6);

    // pre=0, post=0, trigger on the first ARMED cycle
    sample_valid = 1'b0;
    wb_write(3'd1, 8'd0);
    wb_write(3'd3, 8'd0);
    wb_write(3'd0, 8'h01);
    check("s2_armed_direct", 32'(sq_active), 32'd1);
    rd_check("s2_status_armed", 3'd0, 8'h05);
    sq_trigger = 1'b1;
    tick();
    sq_trigger = 1'b0;
    rd_check("s2_status_done", 3'd0, 8'h08);
    check("s2_model_phase", 32'(m_phase), 32'd4);
    rd_check("s2_trig_lo", 3'd5, 8'd0);
    check("s2_capture_addr", 32'(capture_addr), 32'd0);

    // triggers and a start during PRE are ignored
    sample_valid = 1'b1;
    wb_write(3'd1, 8'd3);
    wb_write(3'd3, 8'd2);
    wb_write(3'd0, 8'h01);
    sq_trigger = 1'b1;
    tick();
    rd_check("s3_status_pre", 3'd0, 8'h02);
    sq_trigger = 1'b0;
    wb_write(3'd0, 8'h01);
    sq_trigger = 1'b1;
    tick();
    sq_trigger = 1'b0;
    rd_check("s3_status_armed", 3'd0, 8'h05);
    check("s3_capture_addr", 32'(capture_addr), 32'd3);

    // pre_count write while ARMED is dropped
    wb_write(3'd1, 8'h55);
    rd_check("s3_pre_readback", 3'd1, 8'd3);
    rd_check("s3_still_armed", 3'd0, 8'h05);

    // abort from POST
    sq_trigger = 1'b1;
    tick();
    sq_trigger = 1'b0;
    rd_check("s4_status_post", 3'd0, 8'h06);
    rd_check("s4_trig_lo", 3'd5, 8'd4);
    wb_write(3'd0, 8'h02);
    rd_check("s4_status_idle", 3'd0, 8'h00);
    check("s4_capture_we", 32'(capture_we), 32'd0);
    check("s4_sq_active", 32'(sq_active), 32'd0);

    // abort wins over start in the same write
    wb_write(3'd0, 8'h03);
    rd_check("s4_abort_prio", 3'd0, 8'h00);

    // reset while ARMED
    wb_write(3'd1, 8'd2);
    wb_write(3'd0, 8'h01);
    repeat (3) tick();
    check("s5_armed", 32'(sq_active), 32'd1);
    rst_n = 1'b0;
    #1;
    rd_check("s5_rst_status", 3'd0, 8'h00);
    check("s5_rst_addr", 32'(capture_addr), 32'd0);
    check("s5_rst_we", 32'(capture_we), 32'd0);
    rd_check("s5_rst_pre", 3'd1, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("s5_no_partial_we", 32'(capture_we), 32'd0);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      int r;
      sample_valid = ($urandom_range(0, 9) < 7);
      sq_trigger   = ($urandom_range(0, 9) < 2);
      wb_adr_i     = 16'($urandom);
      wb_dat_i     = 8'($urandom);
      wb_cyc_i     = 1'b0;
      wb_stb_i     = 1'b0;
      wb_we_i      = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        wb_cyc_i = ($urandom_range(0, 7) != 0);
        wb_stb_i = ($urandom_range(0, 7) != 0);
        wb_we_i  = ($urandom_range(0, 7) != 0);
        r = int'($urandom_range(0, 9));
        case (wb_adr_i[2:0])
          3'd0: wb_dat_i[1:0] = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r < 8) ? 2'b11 : 2'b00;
          3'd1, 3'd3: wb_dat_i = 8'($urandom_range(0, 6));
          3'd2, 3'd4: wb_dat_i = (r == 0) ? 8'd1 : 8'd0;
          default: ;
        endcase
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end

    rst_n    = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port sample_valid, input, 1 bit: one ADC sample available this cycle.
REQ-004 SHALL have port sq_trigger, input, 1 bit: trigger pulse from a trigger source; qualified by sq_active.
REQ-005 SHALL have port sq_active, output, 1 bit: high only in ARMED; trigger sources evaluate only while high.
REQ-006 SHALL have port capture_we, output, 1 bit: sample write strobe.
REQ-007 SHALL have port capture_addr, output, 16 bits: sample buffer write address.
REQ-008 SHALL have ports wb_stb_i, wb_cyc_i and wb_we_i, inputs, 1 bit each: Wishbone responder strobes.
REQ-009 SHALL have ports wb_adr_i (input, 16 bits), wb_dat_i (input, 8 bits) and wb_dat_o (output, 8 bits).
REQ-010 SHALL have port wb_ack_o, output, 1 bit: tied to 1, zero wait states.

Function
REQ-011 SHALL define states IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
REQ-012 SHALL decode a register write as wb_cyc_i && wb_stb_i && wb_we_i, with register selected by wb_adr_i[2:0].
REQ-013 SHALL map registers: 0 = control/status; 1/2 = pre_count lo/hi; 3/4 = post_count lo/hi; 5/6 = trig_pos lo/hi (read-only); 7 = reads 0.
REQ-014 SHALL return status on read of reg 0 as {4'b0, state[2:0], sq_active}; reads are combinational on wb_adr_i.
REQ-015 SHALL move IDLE or DONE -> PRE on a reg 0 write with bit0=1 (start), clearing capture_addr and trig_pos.
REQ-016 SHALL ignore start in PRE, ARMED and POST.
REQ-017 SHALL move any state -> IDLE on a reg 0 write with bit1=1 (abort); abort takes priority over start in the same write.
REQ-018 SHALL accept writes to pre_count and post_count only in IDLE or DONE; other writes are dropped.
REQ-019 SHALL drive capture_we = sample_valid while state is PRE, ARMED or POST, and 0 otherwise.
REQ-020 SHALL increment capture_addr by 1 on each capture_we cycle, wrapping modulo 2^16.
REQ-021 SHALL, in PRE, count capture_we cycles and move PRE -> ARMED on the cycle the count reaches pre_count.
REQ-022 SHALL go from start directly to ARMED when pre_count = 0.
REQ-023 SHALL ignore sq_trigger outside ARMED.
REQ-024 SHALL, in ARMED with sq_trigger=1, latch trig_pos = capture_addr of that cycle and move to POST.
REQ-025 SHALL, when post_count = 0, move ARMED -> DONE directly on the trigger instead of entering POST.
REQ-026 SHALL, in POST, move to DONE on the capture_we cycle where the post count reaches post_count.
REQ-027 SHALL drive sq_active from registered state, high in exactly the cycles state=ARMED.
REQ-028 SHALL leave DONE only on start (-> PRE) or abort (-> IDLE).

Reset
REQ-029 SHALL, on rst_n low, reset state to IDLE and clear sq_active, capture_we, capture_addr, trig_pos and internal counters to 0.
REQ-030 SHALL reset pre_count and post_count to 0.
REQ-031 SHALL, on reset mid-capture, not emit a partial capture_we after rst_n deasserts.

Structure
REQ-032 SHALL place state encodings and register offsets in shared package sq_pkg.
REQ-033 SHALL be a single module; one sample counter is reused for the PRE and POST phases.

Verification
REQ-034 SHALL cover: pre=4, post=3, sample_valid constant 1, trigger 2 cycles after ARMED -> trig_pos=6, DONE with capture_addr=9.
REQ-035 SHALL cover: pre=0, post=0, trigger on first ARMED cycle -> DONE next cycle, trig_pos=0, capture_addr=0.
REQ-036 SHALL cover: sq_trigger pulsed during PRE -> no state change; ARMED entered after pre_count samples.
REQ-037 SHALL cover: abort written in POST -> IDLE next cycle, capture_we=0, sq_active=0.
REQ-038 SHALL cover: pre_count write during ARMED -> reg 1 readback unchanged.
REQ-039 SHALL cover: rst_n low in ARMED -> status read 0x00, capture_addr=0.
